// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
//   Round-robin arbiter in front of a small single-ported word memory shared
//   by NUM_PORTS requesters. After reset the memory is filled with
//   memory[i] = i+1, one word per cycle. Then each granted access takes three
//   cycles (IDLE -> ACCESS -> RESP), and resp pulses in the IDLE cycle that
//   follows RESP.
//
//   Optional feature: define SHARED_MEM_COH_TRACK_EN to keep a 2-bit
//   coherency state per word (I=00, M=01, S=10) and report it on coh.
//   Without the macro no state array exists and coh is tied to 2'b00.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        per-port request level, held until resp
//   we         per-port write enable (1 = write)
//   addr       packed per-port word address, port p at [p*ADDR_W +: ADDR_W]
//   wdata      packed per-port write data
//   rdata      packed per-port read data; holds the last read result
//   resp       one-cycle completion pulse to the served port
//   err        out-of-range flag, pulses with resp
//   coh        post-access coherency state of the accessed word
//   init_done  high once the power-up fill is complete
//
// state  | meaning
// INIT   | filling memory one word per cycle; requests ignored
// IDLE   | waiting for a request; round-robin pick from ptr
// ACCESS | memory read or write for the latched request
// RESP   | result registered; resp pulses on the next cycle
module shared_mem_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 50
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS*DATA_W-1:0] rdata,
  output logic [NUM_PORTS-1:0]        resp,
  output logic [NUM_PORTS-1:0]        err,
  output logic [1:0]                  coh,
  output logic                        init_done
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  init_cnt;
  logic              init_last;
  logic [PTR_W-1:0]  ptr, gnt_idx, win_idx, cand_idx;
  logic              win_found, mask_vld;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata, rd_word;
  logic              acc_err;
  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;

  // Extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range  = ({1'b0, lat_addr} < (ADDR_W+1)'(DEPTH));
  assign mem_idx   = lat_addr[IDX_W-1:0];
  assign init_last = (init_cnt == IDX_W'(DEPTH-1));

  // Round-robin search from ptr. The port served last is masked for the
  // first IDLE cycle so a requester that drops req one cycle late is not
  // granted again.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_idx = PTR_W'((int'(ptr) + i) % NUM_PORTS);
      if (!win_found && req[cand_idx] && !(mask_vld && (cand_idx == gnt_idx))) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (init_last) state_nxt = ST_IDLE;
      ST_IDLE:   if (win_found) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      ptr       <= '0;
      gnt_idx   <= '0;
      mask_vld  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_word   <= '0;
      acc_err   <= 1'b0;
      resp      <= '0;
      err       <= '0;
      rdata     <= '0;
    end else begin
      state    <= state_nxt;
      resp     <= '0;
      err      <= '0;
      mask_vld <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_last) init_done <= 1'b1;
          else           init_cnt  <= init_cnt + IDX_W'(1);
        end
        ST_IDLE: begin
          if (win_found) begin
            gnt_idx   <= win_idx;
            lat_we    <= we[win_idx];
            lat_addr  <= addr[int'(win_idx)*ADDR_W +: ADDR_W];
            lat_wdata <= wdata[int'(win_idx)*DATA_W +: DATA_W];
          end
        end
        ST_ACCESS: begin
          acc_err <= !in_range;
          rd_word <= (in_range && !lat_we) ? mem[mem_idx] : '0;
        end
        ST_RESP: begin
          resp[gnt_idx] <= 1'b1;
          err[gnt_idx]  <= acc_err;
          if (!lat_we) rdata[int'(gnt_idx)*DATA_W +: DATA_W] <= rd_word;
          ptr      <= (gnt_idx == PTR_W'(NUM_PORTS-1)) ? '0 : gnt_idx + PTR_W'(1);
          mask_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; INIT rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (state == ST_INIT)
      mem[init_cnt] <= DATA_W'(init_cnt) + DATA_W'(1);
    else if (state == ST_ACCESS && lat_we && in_range)
      mem[mem_idx] <= lat_wdata;
  end

`ifdef SHARED_MEM_COH_TRACK_EN
  localparam logic [1:0] COH_I = 2'b00;
  localparam logic [1:0] COH_M = 2'b01;
  localparam logic [1:0] COH_S = 2'b10;

  logic [1:0] coh_mem [DEPTH];
  logic [1:0] coh_post, acc_coh;

  always_comb begin
    coh_post = COH_I;
    if (in_range) begin
      if (lat_we)                          coh_post = COH_M;
      else if (coh_mem[mem_idx] == COH_I)  coh_post = COH_S;
      else                                 coh_post = coh_mem[mem_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT)
      coh_mem[init_cnt] <= COH_I;
    else if (state == ST_ACCESS && in_range)
      coh_mem[mem_idx] <= coh_post;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_coh <= COH_I;
      coh     <= COH_I;
    end else begin
      if (state == ST_ACCESS) acc_coh <= coh_post;
      if (state == ST_RESP)   coh     <= acc_coh;
    end
  end
`else
  assign coh = 2'b00;
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
module tb_shared_mem_arbiter;

  localparam int NP    = 4;
  localparam int DW    = 16;
  localparam int AW    = 14;
  localparam int DEPTH = 50;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NP-1:0]    req_s = '0;
  logic [NP-1:0]    we_s = '0;
  logic [NP*AW-1:0] addr_s = '0;
  logic [NP*DW-1:0] wdata_s = '0;
  logic [NP*DW-1:0] rdata;
  logic [NP-1:0]    resp;
  logic [NP-1:0]    err;
  logic [1:0]       coh;
  logic             init_done;

  shared_mem_arbiter #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req_s), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .rdata(rdata), .resp(resp), .err(err), .coh(coh),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic        we;
    logic [DW-1:0] rdata;
    logic        err;
    logic [1:0]  coh;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [1:0]    model_coh [DEPTH];
  logic [DW-1:0] last_rd [NP];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = DW'(i + 1);
      model_coh[i] = 2'b00;
    end
    for (int p = 0; p < NP; p++) last_rd[p] = '0;
  endtask

  // Reference behaviour, applied in the order the bench expects service.
  task automatic predict(input int p, input logic w, input int a, input logic [DW-1:0] d);
    exp_t e;
    e.port = p; e.we = w; e.err = 1'b0; e.coh = 2'b00;
    if (a < DEPTH) begin
      if (w) begin
        model_mem[a] = d;
        model_coh[a] = 2'b01;
      end else begin
        last_rd[p] = model_mem[a];
        if (model_coh[a] == 2'b00) model_coh[a] = 2'b10;
      end
      e.coh = model_coh[a];
    end else begin
      e.err = 1'b1;
      if (!w) last_rd[p] = '0;
    end
`ifndef SHARED_MEM_COH_TRACK_EN
    e.coh = 2'b00;
`endif
    e.rdata = last_rd[p];
    sb.push_back(e);
  endtask

  task automatic issue(input int p, input logic w, input int a, input logic [DW-1:0] d, input bit push);
    we_s[p]               = w;
    addr_s[p*AW +: AW]    = AW'(a);
    wdata_s[p*DW +: DW]   = d;
    req_s[p]              = 1'b1;
    if (push) predict(p, w, a, d);
  endtask

  // Wait (bounded) for a response, compare against the scoreboard head,
  // optionally drop the request, then confirm the pulse lasted one cycle.
  task automatic expect_resp(input int budget, input bit drop, output int at);
    int   n;
    exp_t e;
    n  = 0;
    at = cyc;
    while (resp == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (resp == '0) begin
      check("resp_timeout", 32'(resp != '0), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("resp_unexpected", 32'(resp), 32'd0);
      return;
    end
    e  = sb.pop_front();
    at = cyc;
    check("resp_port",  32'(resp), 32'(1 << e.port));
    check("err",        32'(err),  32'(e.err) << e.port);
    check("rdata",      32'(rdata[e.port*DW +: DW]), 32'(e.rdata));
    check("coh",        32'(coh),  32'(e.coh));
    if (drop) req_s[e.port] = 1'b0;
    @(negedge clk);
    check("resp_pulse", 32'(resp), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int extra;
    extra = 0;
    repeat (n) begin
      @(negedge clk);
      if (resp != '0) extra++;
    end
    check(tag, 32'(extra), 32'd0);
  endtask

  initial begin
    int c0, t0, t1, t2, t3, t4, n;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_resp",      32'(resp),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_rdata",     32'(rdata),     32'd0);
    check("rst_coh",       32'(coh),       32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    // Power-up fill takes DEPTH cycles
    reset_n = 1'b1;
    repeat (DEPTH - 1) @(negedge clk);
    check("init_done_early", 32'(init_done), 32'd0);
    @(negedge clk);
    check("init_done", 32'(init_done), 32'd1);

    // Port0 reads addr 7 -> 8, three-edge latency
    c0 = cyc;
    issue(0, 1'b0, 7, '0, 1'b1);
    expect_resp(10, 1'b1, t0);
    check("latency", 32'(t0 - c0), 32'd3);

    // Port3 out-of-range read; leaves ptr at 0
    issue(3, 1'b0, 60, '0, 1'b1);
    expect_resp(10, 1'b1, t0);

    // All four request together: order 0,1,2,3 then 0 again, 3 cycles apart
    for (int p = 0; p < NP; p++) issue(p, 1'b0, 10 + p, '0, 1'b1);
    predict(0, 1'b0, 10, '0);
    expect_resp(10, 1'b0, t0);
    expect_resp(10, 1'b1, t1);
    expect_resp(10, 1'b1, t2);
    expect_resp(10, 1'b1, t3);
    expect_resp(10, 1'b1, t4);
    check("rr_gap01", 32'(t1 - t0), 32'd3);
    check("rr_gap12", 32'(t2 - t1), 32'd3);
    check("rr_gap23", 32'(t3 - t2), 32'd3);
    check("rr_gap30", 32'(t4 - t3), 32'd3);

    // Port1 writes 0xBEEF to addr 3, port2 reads it back
    issue(1, 1'b1, 3, 16'hBEEF, 1'b1);
    expect_resp(10, 1'b1, t0);
    issue(2, 1'b0, 3, '0, 1'b1);
    expect_resp(10, 1'b1, t0);

    // Out-of-range write whose low bits alias addr 5 must not land
    issue(3, 1'b1, 69, 16'h1234, 1'b1);
    expect_resp(10, 1'b1, t0);
    issue(3, 1'b0, 5, '0, 1'b1);
    expect_resp(10, 1'b1, t0);

    // Port0 holds req one cycle past resp while port2 waits
    issue(0, 1'b0, 20, '0, 1'b1);
    @(negedge clk);
    issue(2, 1'b0, 21, '0, 1'b1);
    expect_resp(10, 1'b0, t0);
    req_s[0] = 1'b0;
    expect_resp(10, 1'b1, t1);
    expect_quiet("no_reserve_p0", 8);

    // Lone requester holding one cycle late is not served twice
    issue(1, 1'b0, 30, '0, 1'b1);
    expect_resp(10, 1'b0, t0);
    req_s[1] = 1'b0;
    expect_quiet("no_reserve_p1", 8);

    // Reset during ACCESS of a write to addr 5 aborts it
    issue(0, 1'b1, 5, 16'hDEAD, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    req_s   = '0;
    #1;
    check("abort_resp",      32'(resp),      32'd0);
    check("abort_rdata",     32'(rdata),     32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    expect_quiet("abort_no_resp", 3);
    reset_n = 1'b1;
    model_reset();
    n = 0;
    while (!init_done && n < DEPTH + 10) begin
      @(negedge clk);
      if (resp != '0) n = DEPTH + 100;
      n++;
    end
    check("reinit_done", 32'(init_done), 32'd1);
    issue(0, 1'b0, 5, '0, 1'b1);
    expect_resp(10, 1'b1, t0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requester ports, range 2..8.
REQ-002 Parameter DATA_W, default 16: word width in bits.
REQ-003 Parameter ADDR_W, default 14: per-port address width (word address).
REQ-004 Parameter DEPTH, default 50: number of words stored; DEPTH <= 2**ADDR_W.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_PORTS  per-port request, level, held until resp.
REQ-008 we  in  NUM_PORTS  per-port write enable; 1=write, 0=read; valid with req.
REQ-009 addr  in  NUM_PORTS*ADDR_W  packed per-port word address; port p at [p*ADDR_W +: ADDR_W].
REQ-010 wdata  in  NUM_PORTS*DATA_W  packed per-port write data.
REQ-011 rdata  out  NUM_PORTS*DATA_W  packed per-port read data, valid while that port's resp=1.
REQ-012 resp  out  NUM_PORTS  one-cycle completion pulse to the served port.
REQ-013 err  out  NUM_PORTS  out-of-range flag, pulses with resp.
REQ-014 coh  out  2  coherency state of the accessed word after the access, valid with any resp.
REQ-015 init_done  out  1  high once power-up memory initialisation is complete.

Function
REQ-016 FSM states INIT, IDLE, ACCESS, RESP; after reset the FSM SHALL enter INIT.
REQ-017 INIT: one word per cycle, memory[i] <= i+1 (truncated to DATA_W), i=0..DEPTH-1; state[i] <= I; after word DEPTH-1, init_done=1, go IDLE; requests ignored during INIT.
REQ-018 IDLE: if any eligible req, select winner by round-robin starting at pointer ptr, latch its we/addr/wdata and index, go ACCESS; else stay IDLE.
REQ-019 ACCESS: in-range write stores wdata; in-range read captures memory word; go RESP.
REQ-020 RESP: resp[g]=1 and err[g] as computed for exactly one cycle, all other resp/err bits 0; ptr <= (g+1) mod NUM_PORTS; go IDLE.
REQ-021 Latency: req sampled high in IDLE at edge E gives resp high in cycle after edge E+2; throughput one access per 3 cycles.
REQ-022 Just-served port SHALL be masked in the first IDLE cycle after RESP, so a registered requester dropping req one cycle late is not served twice.
REQ-023 Address >= DEPTH: no memory or state change, rdata for that port = 0, err=1 with resp, coh=I.
REQ-024 Write to self-overlapping address from consecutive grants: later grant observes earlier write (no bypass hazard given 3-cycle spacing).
REQ-025 rdata[p] holds last read value for port p until its next read; write responses leave rdata[p] unchanged.
REQ-026 Requester SHALL keep we/addr/wdata stable from req rise until resp; block samples them only in IDLE.

Reset
REQ-027 reset_n low: resp=0, err=0, rdata=0, coh=0, init_done=0, ptr=0, FSM=INIT, asynchronously.
REQ-028 Reset asserted mid-ACCESS or mid-RESP SHALL abort the transaction with no resp; memory is re-initialised by INIT after release.

Configuration
REQ-029 Macro SHARED_MEM_COH_TRACK_EN defined: per-word 2-bit state (I=00, M=01, S=10); write sets M; read of I sets S; read of S or M unchanged; coh reports the post-access state.
REQ-030 Macro SHARED_MEM_COH_TRACK_EN undefined: no state array instantiated, coh tied to 2'b00, all other behaviour identical.

Verification
REQ-031 Reset release, NUM_PORTS=4, DEPTH=50 -> init_done rises after 50 cycles; read port0 addr 7 -> rdata0=8, resp0 one cycle, err0=0.
REQ-032 Ports 0..3 request simultaneously and hold -> service order 0,1,2,3 then 0 again; each resp one cycle, 3 cycles apart.
REQ-033 Port1 writes 0xBEEF to addr 3, then port2 reads addr 3 -> rdata2=0xBEEF; with COH_TRACK_EN coh=01 on both responses.
REQ-034 Port3 reads addr 60 (DEPTH=50) -> resp3=1, err3=1, rdata3=0, memory unchanged.
REQ-035 Port0 holds req one cycle past resp, port2 also requesting -> port2 served next, port0 not re-served until req re-sampled.
REQ-036 reset_n pulsed low during ACCESS of a write to addr 5 -> no resp; after INIT, read addr 5 returns 6.
